// File: rtl/decoder_onehot_strobe_pkg.sv
// Shared types and constants for the one-hot strobe decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam int MODE_PULSE = 0;
  localparam int MODE_LEVEL = 1;

  // Counter must reach PULSE_LEN-1; keep at least one bit for PULSE_LEN=1.
  function automatic int cnt_width(input int pulse_len);
    return (pulse_len < 1) ? 1 : $clog2(pulse_len + 1);
  endfunction

endpackage

// File: rtl/decoder_onehot_strobe_if.sv
// Select handshake and registered one-hot outputs of the strobe decoder.
interface decoder_onehot_strobe_if #(
  parameter int IN_W  = 3,
  parameter int OUT_N = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_sel;
  logic             clear;
  logic [OUT_N-1:0] out;
  logic             busy;
  logic             err;

  modport master (
    output in_valid, in_sel, clear,
    input  in_ready, out, busy, err
  );

  modport slave (
    input  in_valid, in_sel, clear,
    output in_ready, out, busy, err
  );
endinterface

// File: rtl/decoder_onehot_strobe_onehot_decode.sv
// Combinational binary-to-one-hot decode with an in-range flag.
module onehot_decode #(
  parameter int IN_W  = 3,
  parameter int OUT_N = 8
) (
  input  logic [IN_W-1:0]  i_sel,
  output logic [OUT_N-1:0] o_onehot,
  output logic             o_in_range
);

  always_comb begin
    o_onehot   = '0;
    o_in_range = 1'b0;
    for (int i = 0; i < OUT_N; i++) begin
      if (i_sel == IN_W'(i)) begin
        o_onehot[i] = 1'b1;
        o_in_range  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoder_onehot_strobe.sv
// Registered one-hot select driver: timed strobe (PULSE) or held level (LEVEL).
// state  | meaning
// IDLE   | no line driven, ready for a code
// ACTIVE | PULSE mode strobe running, r_cnt counts cycles of the strobe
// HOLD   | LEVEL mode line held until cleared or replaced
module decoder_onehot_strobe
  import decoder_pkg::*;
#(
  parameter int IN_W      = 3,
  parameter int OUT_N     = 8,
  parameter int PULSE_LEN = 1,
  parameter int MODE      = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  decoder_onehot_strobe_if.slave  bus
);

  localparam int              CNT_W    = cnt_width(PULSE_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_LEN - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [OUT_N-1:0] r_out, w_out_nxt;
  logic             r_err, w_err_nxt;

  logic [OUT_N-1:0] w_onehot;
  logic             w_in_range;
  logic             w_ready;
  logic             w_last;
  logic             w_load;
  logic             w_bad;

  onehot_decode #(
    .IN_W  (IN_W),
    .OUT_N (OUT_N)
  ) u_decode (
    .i_sel      (bus.in_sel),
    .o_onehot   (w_onehot),
    .o_in_range (w_in_range)
  );

  assign w_last = (r_state == ACTIVE) && (r_cnt == CNT_LAST);
  assign w_load = bus.in_valid & w_ready & w_in_range;
  // Out-of-range codes are consumed but leave the FSM untouched.
  assign w_bad  = bus.in_valid & w_ready & ~w_in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_out   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (bus.clear) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load) begin
            w_state_nxt = (MODE == MODE_LEVEL) ? HOLD : ACTIVE;
            w_cnt_nxt   = '0;
          end
        end
        ACTIVE: begin
          if (w_last) begin
            w_cnt_nxt = '0;
            if (!w_load) w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        HOLD:    w_state_nxt = HOLD;
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_out_nxt = r_out;
    w_err_nxt = 1'b0;
    if (MODE == MODE_LEVEL) w_ready = ~bus.clear;
    else                    w_ready = ~bus.clear & ((r_state == IDLE) | w_last);
    if (bus.clear) begin
      w_out_nxt = '0;
    end else begin
      w_err_nxt = w_bad;
      if (w_load)      w_out_nxt = w_onehot;
      else if (w_last) w_out_nxt = '0;
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.out      = r_out;
  assign bus.busy     = (r_state != IDLE);
  assign bus.err      = r_err;

endmodule
